// File: rtl/alu_control_seq.sv
// alu_control_seq
//   Registered, handshaked ALU-control decoder for the multi-cycle MIPS core.
//   Decodes {alu_op, F} into a 4-bit ALU op code and flags undecodable
//   encodings. MULT/DIV hold the pipe for MUL_CYCLES/DIV_CYCLES cycles while
//   the mul/div unit runs.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  input handshake for alu_op[2:0] / F[5:0]
//   out_valid / out_ready output handshake for op[3:0] / multi / illegal
//   unit_start           1-cycle pulse launching the mul/div unit
//   busy                 multi-cycle op in progress
module alu_control_seq #(
    parameter int         MUL_CYCLES = 4,
    parameter int         DIV_CYCLES = 8,
    parameter logic [3:0] ILLEGAL_OP = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] alu_op,
    input  logic [5:0] F,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] op,
    output logic       multi,
    output logic       illegal,
    output logic       unit_start,
    output logic       busy
);

    localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             multi_q, multi_d;
    logic             illegal_q, illegal_d;
    logic             unit_start_q, unit_start_d;
    logic             ready_en_q;

    logic [3:0] dec_op;
    logic       dec_multi, dec_div, dec_illegal;
    logic       accept;

    // Combinational decode of the presented encoding.
    always_comb begin
        dec_op      = ILLEGAL_OP;
        dec_multi   = 1'b0;
        dec_div     = 1'b0;
        dec_illegal = 1'b0;
        unique case (alu_op)
            3'b100: dec_op = 4'b0101;
            3'b010: dec_op = 4'b0110;
            3'b001: begin
                case (F)
                    6'b100100, 6'b001100: dec_op = 4'b0000;
                    6'b100101, 6'b001101: dec_op = 4'b0001;
                    6'b100110, 6'b001110: dec_op = 4'b0010;
                    6'b100111:            dec_op = 4'b0011;
                    6'b100000, 6'b001000: dec_op = 4'b0101;
                    6'b100010:            dec_op = 4'b0110;
                    6'b101010, 6'b001010: dec_op = 4'b0111;
                    6'b000010:            dec_op = 4'b1000;
                    6'b000000:            dec_op = 4'b1001;
                    6'b000011:            dec_op = 4'b1010;
                    6'b011000: begin
                        dec_op    = 4'b1011;
                        dec_multi = 1'b1;
                    end
                    6'b011010: begin
                        dec_op    = 4'b1100;
                        dec_multi = 1'b1;
                        dec_div   = 1'b1;
                    end
                    default:              dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ready_en_q keeps in_ready low until the first clock after reset release.
    assign in_ready   = ready_en_q & ((state_q == S_IDLE) | ((state_q == S_OUT) & out_ready));
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state_q == S_OUT);
    assign busy       = (state_q == S_WAIT);
    assign op         = op_q;
    assign multi      = multi_q;
    assign illegal    = illegal_q;
    assign unit_start = unit_start_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        multi_d      = multi_q;
        illegal_d    = illegal_q;
        unit_start_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_OUT: begin
                // A drained result with no follow-on input returns to IDLE;
                // an accept (from IDLE or a draining OUT) loads the next op.
                if (state_q == S_OUT && out_ready && !accept)
                    state_d = S_IDLE;
                if (accept) begin
                    op_d      = dec_op;
                    multi_d   = dec_multi;
                    illegal_d = dec_illegal;
                    if (dec_multi) begin
                        state_d      = S_WAIT;
                        cnt_d        = dec_div ? DIV_LOAD : MUL_LOAD;
                        unit_start_d = 1'b1;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_OUT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            multi_q      <= 1'b0;
            illegal_q    <= 1'b0;
            unit_start_q <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            multi_q      <= multi_d;
            illegal_q    <= illegal_d;
            unit_start_q <= unit_start_d;
            ready_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

    localparam int MULN = 4;
    localparam int DIVN = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [2:0] alu_op;
    logic [5:0] F;
    logic       out_valid, out_ready;
    logic [3:0] op;
    logic       multi, illegal, unit_start, busy;

    alu_control_seq #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .ILLEGAL_OP(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .F(F), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .multi(multi), .illegal(illegal), .unit_start(unit_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: funct lookup table built from the decode rules.
    logic [3:0] lut_op [64];
    bit         lut_ok [64];

    task automatic lut_set(input logic [5:0] f, input logic [3:0] o);
        lut_op[f] = o;
        lut_ok[f] = 1'b1;
    endtask

    task automatic build_lut();
        for (int i = 0; i < 64; i++) begin
            lut_op[i] = 4'hF;
            lut_ok[i] = 1'b0;
        end
        lut_set(6'b100100, 4'h0); lut_set(6'b001100, 4'h0);
        lut_set(6'b100101, 4'h1); lut_set(6'b001101, 4'h1);
        lut_set(6'b100110, 4'h2); lut_set(6'b001110, 4'h2);
        lut_set(6'b100111, 4'h3);
        lut_set(6'b100000, 4'h5); lut_set(6'b001000, 4'h5);
        lut_set(6'b100010, 4'h6);
        lut_set(6'b101010, 4'h7); lut_set(6'b001010, 4'h7);
        lut_set(6'b000010, 4'h8);
        lut_set(6'b000000, 4'h9);
        lut_set(6'b000011, 4'hA);
        lut_set(6'b011000, 4'hB);
        lut_set(6'b011010, 4'hC);
    endtask

    function automatic void ref_decode(input logic [2:0] a, input logic [5:0] f,
                                       output logic [3:0] o, output bit mu,
                                       output bit il, output int n);
        o = 4'hF; mu = 0; il = 0; n = 0;
        if (a == 3'b100)      o = 4'h5;
        else if (a == 3'b010) o = 4'h6;
        else if (a == 3'b001) begin
            o  = lut_op[f];
            il = !lut_ok[f];
            mu = (f == 6'b011000) || (f == 6'b011010);
            n  = (f == 6'b011010) ? DIVN : MULN;
        end else il = 1;
    endfunction

    // Cycle-level behavioural model state.
    bit         m_ready_en, m_has_out, m_ustart, m_multi, m_ill;
    int         m_wait_left;
    logic [3:0] m_op;

    task automatic model_reset();
        m_ready_en = 0; m_has_out = 0; m_ustart = 0; m_multi = 0; m_ill = 0;
        m_wait_left = 0; m_op = 4'h0;
    endtask

    // One clock: compare at negedge, advance model, return at posedge+1.
    task automatic step();
        bit acc, exp_ir, mu, il;
        logic [3:0] o;
        int n;
        @(negedge clk);
        exp_ir = m_ready_en && (m_wait_left == 0) && (!m_has_out || out_ready);
        chk("in_ready", int'(in_ready), int'(exp_ir));
        chk("out_valid", int'(out_valid), int'(m_has_out));
        chk("busy", int'(busy), int'(m_wait_left > 0));
        chk("unit_start", int'(unit_start), int'(m_ustart));
        if (m_wait_left == 0) begin
            chk("op", int'(op), int'(m_op));
            chk("multi", int'(multi), int'(m_multi));
            chk("illegal", int'(illegal), int'(m_ill));
        end
        acc = in_valid && exp_ir;
        ref_decode(alu_op, F, o, mu, il, n);
        m_ustart = 0;
        if (m_wait_left > 0) begin
            m_wait_left--;
            if (m_wait_left == 0) m_has_out = 1;
        end else if (!(m_has_out && !out_ready)) begin
            m_has_out = 0;
            if (acc) begin
                m_op = o; m_multi = mu; m_ill = il;
                if (mu) begin
                    m_wait_left = n;
                    m_ustart    = 1;
                end else m_has_out = 1;
            end
        end
        m_ready_en = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] a, input logic [5:0] f, input bit r);
        in_valid = v; alu_op = a; F = f; out_ready = r;
    endtask

    typedef struct {
        logic [2:0] a;
        logic [5:0] f;
        logic [3:0] e_op;
        bit         e_ill;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [3:0] held;
        int k, bcnt, ucnt;
        build_lut();
        model_reset();
        rst_n = 0;
        drive(0, 3'b000, 6'b0, 0);
        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_op", int'(op), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1;
        step();   // in_ready still low on the first cycle after release

        // Table-driven single-cycle vectors, out_ready high, back-to-back.
        vecs.push_back('{3'b100, 6'b110111, 4'h5, 0});
        vecs.push_back('{3'b010, 6'b000000, 4'h6, 0});
        vecs.push_back('{3'b001, 6'b100100, 4'h0, 0});
        vecs.push_back('{3'b001, 6'b100000, 4'h5, 0});
        vecs.push_back('{3'b001, 6'b100010, 4'h6, 0});
        vecs.push_back('{3'b001, 6'b000011, 4'hA, 0});
        vecs.push_back('{3'b001, 6'b001101, 4'h1, 0});
        vecs.push_back('{3'b001, 6'b100111, 4'h3, 0});
        vecs.push_back('{3'b001, 6'b001010, 4'h7, 0});
        vecs.push_back('{3'b001, 6'b000000, 4'h9, 0});
        vecs.push_back('{3'b001, 6'b000010, 4'h8, 0});
        vecs.push_back('{3'b001, 6'b111111, 4'hF, 1});
        vecs.push_back('{3'b011, 6'b100000, 4'hF, 1});
        vecs.push_back('{3'b000, 6'b100000, 4'hF, 1});
        foreach (vecs[i]) begin
            drive(1, vecs[i].a, vecs[i].f, 1);
            step();
            chk("vec_out_valid", int'(out_valid), 1);
            chk("vec_in_ready", int'(in_ready), 1);
            chk("vec_op", int'(op), int'(vecs[i].e_op));
            chk("vec_illegal", int'(illegal), int'(vecs[i].e_ill));
        end
        drive(0, 3'b000, 6'b0, 1);
        step();
        step();

        // DIV: busy for DIVN cycles, out_valid at accept+DIVN+1.
        drive(1, 3'b001, 6'b011010, 1);
        step();
        drive(0, 3'b000, 6'b0, 1);
        k = 1; bcnt = 0; ucnt = 0;
        while (!out_valid && k < 30) begin
            if (busy) bcnt++;
            if (unit_start) ucnt++;
            if (in_ready) chk("div_in_ready", int'(in_ready), 0);
            step();
            k++;
        end
        chk("div_latency", k, DIVN + 1);
        chk("div_busy_cycles", bcnt, DIVN);
        chk("div_start_pulses", ucnt, 1);
        chk("div_op", int'(op), 4'hC);
        chk("div_multi", int'(multi), 1);
        step();

        // Output stall: out_ready low for 5 cycles with a new input waiting.
        drive(1, 3'b001, 6'b100110, 0);
        step();
        held = op;
        drive(1, 3'b010, 6'b0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("stall_op", int'(op), int'(held));
        chk("stall_in_ready", int'(in_ready), 0);
        drive(1, 3'b010, 6'b0, 1);
        step();
        chk("stall_release_op", int'(op), 4'h6);
        drive(0, 3'b000, 6'b0, 1);
        step();

        // Reset in the middle of a MULT wait.
        drive(1, 3'b001, 6'b011000, 1);
        step();
        drive(0, 3'b000, 6'b0, 1);
        step();
        #2;
        rst_n = 0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_unit_start", int'(unit_start), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_op", int'(op), 0);
        chk("abort_multi", int'(multi), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < MULN + 3; i++) step();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] a;
            logic [5:0] f;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = 3'b100;
                1: a = 3'b010;
                2: a = 3'($urandom_range(0, 7));
                default: a = 3'b001;
            endcase
            if ($urandom_range(0, 9) == 0) f = ($urandom_range(0, 1) == 1) ? 6'b011010 : 6'b011000;
            else f = 6'($urandom_range(0, 63));
            drive($urandom_range(0, 3) != 0, a, f, $urandom_range(0, 3) != 0);
            step();
        end
        drive(0, 3'b000, 6'b0, 1);
        for (int i = 0; i < DIVN + 3; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
